perf_event_counter: RTL and testbench
=====================================

Name: perf_event_counter

Overview:
- Synthesizable, parametrised bank of performance-event counters inside CPU.
- Counts per-cycle pipeline/cache events: stall, flush, dcache read/write hit/miss, write-back.
- Test benches and debug logic read the counts through a snapshot bank, so they no longer need hierarchical probing of internal signals.
- Each channel counts in one of two modes: level (one count per asserted cycle, for stall/flush) or edge (one count per event, for a miss that holds stall for many cycles).

Parameters:
- NUM_CH, 8, number of event channels (1..32).
- CNT_W, 32, counter width in bits (2..64).
- SAT_EN, 1, 1 = saturate at all-ones; 0 = wrap to zero.
- EDGE_MASK, {NUM_CH{1'b0}}, per-channel mode; bit=1 selects edge mode (count 0->1 transitions of event_i[ch]), bit=0 selects level mode.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  global count enable; while 0, no counter increments.
- event_i  in  NUM_CH  event strobes, sampled each rising edge.
- freeze_i  in  1  level; while 1, live counters hold.
- clear_i  in  1  synchronous pulse; zeroes live counters and overflow flags.
- snap_i  in  1  synchronous pulse; copies all live counters into the shadow bank.
- rd_en_i  in  1  read request for one shadow entry.
- rd_sel_i  in  max(1,$clog2(NUM_CH))  channel to read.
- rd_data_o  out  CNT_W  shadow value of the selected channel.
- rd_valid_o  out  1  one-cycle pulse qualifying rd_data_o.
- ovf_o  out  NUM_CH  sticky per-channel overflow flags.
- any_ovf_o  out  1  OR of ovf_o.

Behaviour:
- Reset (rst_i=0, asynchronous) clears:
  - live counters, shadow bank and edge-history register;
  - ovf_o, rd_data_o and rd_valid_o.
  - All outputs read 0 while rst_i=0.
  - Reset asserted mid-read kills the pending rd_valid_o.
- Increment condition for channel ch: inc[ch] = start_i & ~freeze_i & ~clear_i & hit[ch].
  - Level mode: hit = event_i[ch].
  - Edge mode: hit = event_i[ch] & ~prev[ch].
- prev[ch] <= event_i[ch] every cycle. This update happens regardless of start_i, freeze_i and clear_i, so a level held across freeze release or clear is not counted again.
- Counter update when inc=1:
  - counter == all-ones and SAT_EN=1: counter holds; ovf[ch] <= 1.
  - counter == all-ones and SAT_EN=0: counter <= 0; ovf[ch] <= 1.
  - otherwise: counter <= counter + 1.
- ovf flags are sticky. Only clear_i or reset drops them.
- clear_i has priority over any same-cycle event; the event is lost. Counter reads 0 the next cycle.
- snap_i: shadow[ch] <= live[ch] for all ch, in the same edge, atomically.
  - The captured value excludes any increment occurring in that same cycle.
  - snap_i and clear_i in the same cycle: shadow captures the pre-clear values, live counters go to 0.
  - snap_i is legal while frozen.
- Read path, one-cycle latency:
  - rd_en_i=1 at edge N gives rd_valid_o=1 and rd_data_o=shadow[rd_sel_i] after edge N, i.e. valid during cycle N+1.
  - rd_en_i held high returns one valid per cycle.
  - rd_sel_i >= NUM_CH returns 0 with rd_valid_o=1.
  - snap_i and rd_en_i in the same cycle: read returns the old shadow value.
- rd_data_o holds its last value when rd_valid_o=0.
- Read state: IDLE (rd_valid_o=0) -> RESP on rd_en_i; RESP -> RESP if rd_en_i, else IDLE.
- any_ovf_o is a combinational OR of the registered ovf flags.

Test Plan:
1. Level count (NUM_CH=8, CNT_W=32): start_i=1, event_i[0]=1 for 7 cycles, snap_i, rd_sel_i=0 -> rd_data_o=7, rd_valid_o exactly one cycle after rd_en_i.
2. Edge mode (EDGE_MASK[1]=1): event_i[1] high 40 cycles, low 3 cycles, high 10 cycles -> shadow[1]=2 after snap. Same stimulus on level channel 0 -> 50.
3. Overflow (CNT_W=4):
   - SAT_EN=1, 20 level events -> count 15, ovf_o[0]=1, any_ovf_o=1.
   - SAT_EN=0, 20 events -> count 4, ovf_o[0]=1.
   - clear_i -> count 0, ovf_o=0.
4. Priorities: counter at 9, then snap_i+clear_i+event in one cycle -> shadow=9, live=0. Next cycle event -> live=1.
5. Gating:
   - freeze_i=1 for 5 event cycles -> no change.
   - start_i=0 -> no change.
   - Edge channel held high across freeze release -> no extra count.
6. Reset mid-operation: counters at 12 and rd_en_i pending; pull rst_i low between clock edges -> rd_valid_o, ovf_o and all counts 0 immediately. After release, counting resumes from 0.

Source files
------------

// File: rtl/perf_event_counter.sv
// Bank of per-channel performance-event counters with a snapshot shadow bank
// and a one-cycle-latency read port for debug and testbench access.
module perf_event_counter #(
   parameter int                NUM_CH    = 8,
   parameter int                CNT_W     = 32,
   parameter bit                SAT_EN    = 1'b1,
   parameter logic [NUM_CH-1:0] EDGE_MASK = {NUM_CH{1'b0}},
   localparam int               SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [NUM_CH-1:0] event_i,
   input  logic              freeze_i,
   input  logic              clear_i,
   input  logic              snap_i,
   input  logic              rd_en_i,
   input  logic [SEL_W-1:0]  rd_sel_i,
   output logic [CNT_W-1:0]  rd_data_o,
   output logic              rd_valid_o,
   output logic [NUM_CH-1:0] ovf_o,
   output logic              any_ovf_o
);

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RESP = 1'b1
   } rdState_t;

   logic [CNT_W-1:0]  r_cnt    [NUM_CH];
   logic [CNT_W-1:0]  r_shadow [NUM_CH];
   logic [NUM_CH-1:0] r_prev;
   logic [NUM_CH-1:0] r_ovf;
   logic [CNT_W-1:0]  r_rdData;
   rdState_t          r_rdState;
   rdState_t          w_rdStateNext;

   logic [NUM_CH-1:0] w_hit;
   logic [NUM_CH-1:0] w_inc;
   logic [CNT_W-1:0]  w_rdShadow;

   // Edge channels only see a hit on a 0->1 transition; level channels on every high cycle.
   always_comb begin
      w_hit = event_i & ~(r_prev & EDGE_MASK);
      w_inc = {NUM_CH{start_i & ~freeze_i & ~clear_i}} & w_hit;
   end

   // History tracks the raw strobe every cycle so a held level is never re-counted after gating lifts.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_prev <= '0;
      end else begin
         r_prev <= event_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ovf <= '0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            r_cnt[ch] <= '0;
         end
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (clear_i) begin
               r_cnt[ch] <= '0;
               r_ovf[ch] <= 1'b0;
            end else if (w_inc[ch]) begin
               if (&r_cnt[ch]) begin
                  r_ovf[ch] <= 1'b1;
                  if (!SAT_EN) begin
                     r_cnt[ch] <= '0;
                  end
               end else begin
                  r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
               end
            end
         end
      end
   end

   // Shadow takes the pre-update live values, so a same-cycle increment or clear is not visible.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            r_shadow[ch] <= '0;
         end
      end else if (snap_i) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            r_shadow[ch] <= r_cnt[ch];
         end
      end
   end

   always_comb begin
      w_rdShadow = '0;
      if (32'(rd_sel_i) < NUM_CH) begin
         w_rdShadow = r_shadow[rd_sel_i];
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_rdState <= RD_IDLE;
      end else begin
         r_rdState <= w_rdStateNext;
      end
   end

   always_comb begin
      w_rdStateNext = r_rdState;
      case (r_rdState)
         RD_IDLE: begin
            if (rd_en_i) begin
               w_rdStateNext = RD_RESP;
            end
         end
         RD_RESP: begin
            if (!rd_en_i) begin
               w_rdStateNext = RD_IDLE;
            end
         end
         default: w_rdStateNext = RD_IDLE;
      endcase
   end

   // Data only moves on a request so it holds its last value between responses.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_rdData <= '0;
      end else if (rd_en_i) begin
         r_rdData <= w_rdShadow;
      end
   end

   assign rd_data_o  = r_rdData;
   assign rd_valid_o = (r_rdState == RD_RESP);
   assign ovf_o      = r_ovf;
   assign any_ovf_o  = |r_ovf;

endmodule

// File: tb/tb_perf_event_counter.sv
// Randomized and directed bench for perf_event_counter: a saturating 6-bit bank and
// a wrapping 4-bit bank share stimulus and are scored against a cycle-level model.
module tb_perf_event_counter;

   logic       clk = 1'b0;
   logic       rstN = 1'b1;
   logic       start = 1'b0, freeze = 1'b0, clear = 1'b0, snap = 1'b0, rdEn = 1'b0;
   logic [2:0] rdSel = '0;
   logic [5:0] ev = '0;

   logic [5:0] rdDataA;
   logic       rdValidA, anyA;
   logic [5:0] ovfA;
   logic [3:0] rdDataB;
   logic       rdValidB, anyB;
   logic [2:0] ovfB;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   perf_event_counter #(
      .NUM_CH(6), .CNT_W(6), .SAT_EN(1'b1), .EDGE_MASK(6'b101010)
   ) dutA (
      .clk_i(clk), .rst_i(rstN), .start_i(start), .event_i(ev),
      .freeze_i(freeze), .clear_i(clear), .snap_i(snap),
      .rd_en_i(rdEn), .rd_sel_i(rdSel),
      .rd_data_o(rdDataA), .rd_valid_o(rdValidA), .ovf_o(ovfA), .any_ovf_o(anyA)
   );

   perf_event_counter #(
      .NUM_CH(3), .CNT_W(4), .SAT_EN(1'b0), .EDGE_MASK(3'b010)
   ) dutB (
      .clk_i(clk), .rst_i(rstN), .start_i(start), .event_i(ev[2:0]),
      .freeze_i(freeze), .clear_i(clear), .snap_i(snap),
      .rd_en_i(rdEn), .rd_sel_i(rdSel[1:0]),
      .rd_data_o(rdDataB), .rd_valid_o(rdValidB), .ovf_o(ovfB), .any_ovf_o(anyB)
   );

   // Reference model: plain integer counts per bank/channel, updated once per clock edge.
   int   nch  [2] = '{6, 3};
   int   maxv [2] = '{63, 15};
   bit   satM [2] = '{1'b1, 1'b0};
   bit   edgeM[2][6] = '{'{0, 1, 0, 1, 0, 1}, '{0, 1, 0, 0, 0, 0}};
   int   cnt   [2][6];
   int   shadow[2][6];
   bit   prevM [2][6];
   bit   ovfM  [2][6];
   int   expQA[$];
   int   expQB[$];
   int   lastA = 0, lastB = 0;
   bit   inReset = 1'b0;

   function automatic void check(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void modelEdge(int d);
      int  sel;
      int  rv;
      bit  hit;
      sel = (d == 0) ? int'(rdSel) : int'(rdSel[1:0]);
      if (rdEn) begin
         rv = (sel < nch[d]) ? shadow[d][sel] : 0;
         if (d == 0) expQA.push_back(rv);
         else        expQB.push_back(rv);
      end
      for (int ch = 0; ch < nch[d]; ch++) begin
         hit = ev[ch] && !(edgeM[d][ch] && prevM[d][ch]);
         if (snap) shadow[d][ch] = cnt[d][ch];
         if (clear) begin
            cnt[d][ch]  = 0;
            ovfM[d][ch] = 1'b0;
         end else if (start && !freeze && hit) begin
            if (cnt[d][ch] == maxv[d]) begin
               ovfM[d][ch] = 1'b1;
               cnt[d][ch]  = satM[d] ? maxv[d] : 0;
            end else begin
               cnt[d][ch] = cnt[d][ch] + 1;
            end
         end
         prevM[d][ch] = ev[ch];
      end
   endfunction

   function automatic void modelReset();
      for (int d = 0; d < 2; d++) begin
         for (int ch = 0; ch < 6; ch++) begin
            cnt[d][ch] = 0; shadow[d][ch] = 0; prevM[d][ch] = 0; ovfM[d][ch] = 0;
         end
      end
      expQA.delete();
      expQB.delete();
      lastA = 0;
      lastB = 0;
   endfunction

   task automatic applyStimulus(input bit s, input bit f, input bit c, input bit sn,
                                input bit re, input logic [2:0] sel, input logic [5:0] e);
      start = s; freeze = f; clear = c; snap = sn; rdEn = re; rdSel = sel; ev = e;
      @(posedge clk);
      if (!inReset) begin
         modelEdge(0);
         modelEdge(1);
      end
      #1;
   endtask

   task automatic checkOutput();
      logic [5:0] vA;
      logic [2:0] vB;
      int         exp;
      vA = '0;
      vB = '0;
      for (int ch = 0; ch < 6; ch++) vA[ch] = ovfM[0][ch];
      for (int ch = 0; ch < 3; ch++) vB[ch] = ovfM[1][ch];
      check("validA", rdValidA, expQA.size() > 0);
      if (expQA.size() > 0) begin
         exp = expQA.pop_front();
         check("dataA", rdDataA, exp);
         lastA = exp;
      end else begin
         check("holdA", rdDataA, lastA);
      end
      check("validB", rdValidB, expQB.size() > 0);
      if (expQB.size() > 0) begin
         exp = expQB.pop_front();
         check("dataB", rdDataB, exp);
         lastB = exp;
      end else begin
         check("holdB", rdDataB, lastB);
      end
      check("ovfA", ovfA, vA);
      check("anyA", anyA, |vA);
      check("ovfB", ovfB, vB);
      check("anyB", anyB, |vB);
   endtask

   always @(negedge clk) checkOutput();

   task automatic checkAllZero(string tag);
      check({tag, "_validA"}, rdValidA, 0);
      check({tag, "_dataA"}, rdDataA, 0);
      check({tag, "_ovfA"}, ovfA, 0);
      check({tag, "_anyA"}, anyA, 0);
      check({tag, "_validB"}, rdValidB, 0);
      check({tag, "_dataB"}, rdDataB, 0);
      check({tag, "_ovfB"}, ovfB, 0);
   endtask

   initial begin
      modelReset();
      inReset = 1'b1;
      #2 rstN = 1'b0;
      #1 checkAllZero("reset");
      repeat (2) applyStimulus(1, 0, 0, 0, 1, 0, 6'h3f);
      #1 rstN = 1'b1;
      inReset = 1'b0;

      // Level count of seven cycles, read back one cycle after the request.
      repeat (7) applyStimulus(1, 0, 0, 0, 0, 0, 6'b000001);
      applyStimulus(1, 0, 0, 1, 0, 0, 6'b0);
      applyStimulus(1, 0, 0, 0, 1, 0, 6'b0);
      check("t1_validA", rdValidA, 1);
      check("t1_dataA", rdDataA, 7);
      applyStimulus(1, 0, 0, 0, 0, 0, 6'b0);
      check("t1_validDrop", rdValidA, 0);

      // Edge channel 1 vs level channel 0 under the same 40/3/10 pattern.
      applyStimulus(1, 0, 1, 0, 0, 0, 6'b0);
      repeat (40) applyStimulus(1, 0, 0, 0, 0, 0, 6'b000011);
      repeat (3)  applyStimulus(1, 0, 0, 0, 0, 0, 6'b000000);
      repeat (10) applyStimulus(1, 0, 0, 0, 0, 0, 6'b000011);
      applyStimulus(1, 0, 0, 1, 0, 0, 6'b0);
      applyStimulus(1, 0, 0, 0, 1, 1, 6'b0);
      check("t2_edge", rdDataA, 2);
      applyStimulus(1, 0, 0, 0, 1, 0, 6'b0);
      check("t2_level", rdDataA, 50);

      // Overflow: 20 events wrap the 4-bit bank to 4; 70 events saturate the 6-bit bank.
      applyStimulus(1, 0, 1, 0, 0, 0, 6'b0);
      repeat (20) applyStimulus(1, 0, 0, 0, 0, 0, 6'b000001);
      applyStimulus(1, 0, 0, 1, 0, 0, 6'b0);
      applyStimulus(1, 0, 0, 0, 1, 0, 6'b0);
      check("t3_wrapData", rdDataB, 4);
      check("t3_wrapOvf", ovfB[0], 1);
      check("t3_noOvfA", anyA, 0);
      repeat (50) applyStimulus(1, 0, 0, 0, 0, 0, 6'b000001);
      applyStimulus(1, 0, 0, 1, 0, 0, 6'b0);
      applyStimulus(1, 0, 0, 0, 1, 0, 6'b0);
      check("t3_satData", rdDataA, 63);
      check("t3_satOvf", ovfA[0], 1);
      check("t3_satAny", anyA, 1);
      applyStimulus(1, 0, 1, 1, 0, 0, 6'b000001);
      applyStimulus(1, 0, 0, 1, 0, 0, 6'b0);
      applyStimulus(1, 0, 0, 0, 1, 0, 6'b0);
      check("t3_clearData", rdDataA, 0);
      check("t3_clearOvf", ovfA, 0);

      // Snap + clear + event in one cycle: shadow keeps 9, live restarts from the next event.
      repeat (9) applyStimulus(1, 0, 0, 0, 0, 0, 6'b000001);
      applyStimulus(1, 0, 1, 1, 0, 0, 6'b000001);
      applyStimulus(1, 0, 0, 0, 1, 0, 6'b000001);
      check("t4_shadow", rdDataA, 9);
      applyStimulus(1, 0, 0, 1, 0, 0, 6'b0);
      applyStimulus(1, 0, 0, 0, 1, 0, 6'b0);
      check("t4_live", rdDataA, 1);

      // Gating: freeze, start low, and an edge level held across freeze release.
      applyStimulus(1, 0, 1, 0, 0, 0, 6'b0);
      repeat (5) applyStimulus(1, 1, 0, 0, 0, 0, 6'b000011);
      repeat (5) applyStimulus(1, 0, 0, 0, 0, 0, 6'b000010);
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 6'b000001);
      applyStimulus(0, 0, 0, 0, 0, 0, 6'b000000);
      applyStimulus(0, 0, 0, 0, 0, 0, 6'b000011);
      applyStimulus(1, 0, 0, 1, 0, 0, 6'b0);
      applyStimulus(1, 0, 0, 0, 1, 1, 6'b0);
      check("t5_edgeHeld", rdDataA, 0);
      applyStimulus(1, 0, 0, 0, 1, 0, 6'b0);
      check("t5_gated", rdDataA, 0);
      applyStimulus(1, 0, 0, 0, 1, 7, 6'b0);
      check("t5_outOfRange", rdDataA, 0);

      // Reset between edges while a read response is being presented.
      repeat (12) applyStimulus(1, 0, 0, 0, 0, 0, 6'b000001);
      applyStimulus(1, 0, 0, 1, 0, 0, 6'b0);
      applyStimulus(1, 0, 0, 0, 1, 0, 6'b0);
      check("t6_preReset", rdDataA, 12);
      #1 rstN = 1'b0;
      inReset = 1'b1;
      modelReset();
      #1 checkAllZero("t6_async");
      repeat (2) applyStimulus(1, 0, 0, 0, 1, 0, 6'b000001);
      #1 rstN = 1'b1;
      inReset = 1'b0;
      repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 6'b000001);
      applyStimulus(1, 0, 0, 1, 0, 0, 6'b0);
      applyStimulus(1, 0, 0, 0, 1, 0, 6'b0);
      check("t6_resume", rdDataA, 3);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 9) != 0,
                       $urandom_range(0, 9) == 0,
                       $urandom_range(0, 49) == 0,
                       $urandom_range(0, 6) == 0,
                       $urandom_range(0, 9) < 4,
                       3'($urandom_range(0, 7)),
                       6'($urandom));
      end
      repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 6'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
